// File: rtl/tm1638_pkg.sv
// Shared command encodings, state type and RAM geometry for the TM1638 responder.
package tm1638_pkg;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int DCMD_READ_BIT  = 1;
  localparam int DCMD_FIXED_BIT = 2;

  localparam int RAM_DEPTH = 16;

  typedef enum logic [1:0] {IDLE, CMD, DATA, READ} state_e;
endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses; output delay STAGES cycles,
// edge pulses are combinational off the last stage. No backpressure.
module tm1638_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Q,
  output logic o_Rise,
  output logic o_Fall
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_D};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign o_Q    = sync_q[STAGES-1];
  assign o_Rise = o_Q & ~prev_q;
  assign o_Fall = ~o_Q & prev_q;
endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: STB/CLK/DIO decode into display RAM/control, key word readback.
// Bytes report ~SYNC_STAGES+1 cycles after the 8th CLK rise; no backpressure. TM1638_RESP_ERR_EN adds error outputs.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int READ_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_SPI_Stb,
  input  logic                  i_SPI_Clk,
  inout  wire                   io_SPI_Dio,
  input  logic [READ_WIDTH-1:0] i_Keys,
  input  logic [3:0]            i_Ram_RAddr,
  output logic [7:0]            o_Ram_RData,
  output logic                  o_Disp_On,
  output logic [2:0]            o_Disp_Bright,
  output logic                  o_Byte_Valid,
  output logic [7:0]            o_Byte,
`ifdef TM1638_RESP_ERR_EN
  output logic                  o_Frame_Err,
  output logic [7:0]            o_Err_Cnt,
`endif
  output logic                  o_Read_Active
);
  localparam int CW = $clog2(READ_WIDTH) + 1;
  localparam logic [CW-1:0] TX_LAST = CW'(READ_WIDTH);

  logic stb_s, stb_rise, stb_fall;
  logic clk_s, clk_rise, clk_fall;
  logic dio_s, dio_rise, dio_fall;
  logic sig_unused;

  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_stb (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_D(i_SPI_Stb),
    .o_Q(stb_s), .o_Rise(stb_rise), .o_Fall(stb_fall));
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_D(i_SPI_Clk),
    .o_Q(clk_s), .o_Rise(clk_rise), .o_Fall(clk_fall));
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dio (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_D(io_SPI_Dio),
    .o_Q(dio_s), .o_Rise(dio_rise), .o_Fall(dio_fall));

  assign sig_unused = ^{stb_fall, clk_s, dio_rise, dio_fall};

  state_e                state_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic [7:0]            shift_d;
  logic [3:0]            ptr_q;
  logic                  fixed_q;
  logic [READ_WIDTH-1:0] keys_q;
  logic [CW-1:0]         tx_cnt_q;
  logic                  dio_oe_q;
  logic                  dio_out_q;
  logic                  byte_vld_q;
  logic [7:0]            byte_q;
  logic                  disp_on_q;
  logic [2:0]            bright_q;
  logic [7:0]            rdata_q;
  logic [7:0]            ram_q [RAM_DEPTH];

  // LSB first: the newest bit enters at the top and walks down to bit 0.
  assign shift_d = {dio_s, shift_q[7:1]};

`ifdef TM1638_RESP_ERR_EN
  logic       read_sel_q;
  logic       err_hit;
  logic       frame_err_q;
  logic [7:0] err_cnt_q;

  always_comb begin
    err_hit = 1'b0;
    if (stb_rise) begin
      err_hit = (bit_cnt_q != 3'd0) || (state_q == READ && tx_cnt_q != TX_LAST);
    end else if (state_q == DATA && clk_rise && bit_cnt_q == 3'd7) begin
      err_hit = read_sel_q;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else if (err_hit) begin
      frame_err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_Frame_Err = frame_err_q;
  assign o_Err_Cnt   = err_cnt_q;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 4'd0;
      fixed_q    <= 1'b0;
      keys_q     <= '0;
      tx_cnt_q   <= '0;
      dio_oe_q   <= 1'b0;
      dio_out_q  <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
      disp_on_q  <= 1'b0;
      bright_q   <= 3'd0;
`ifdef TM1638_RESP_ERR_EN
      read_sel_q <= 1'b0;
`endif
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
    end else begin
      byte_vld_q <= 1'b0;
      if (stb_rise) begin
        // Frame end wins over everything: partial bytes are simply dropped.
        state_q   <= IDLE;
        bit_cnt_q <= 3'd0;
        dio_oe_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!stb_s) begin
              state_q   <= CMD;
              bit_cnt_q <= 3'd0;
            end
          end
          CMD, DATA: begin
            if (clk_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_vld_q <= 1'b1;
                byte_q     <= shift_d;
                if (state_q == DATA) begin
                  ram_q[ptr_q] <= shift_d;
                  if (!fixed_q) ptr_q <= ptr_q + 4'd1;
                end else begin
                  case (shift_d[7:6])
                    CMD_DATA: begin
`ifdef TM1638_RESP_ERR_EN
                      read_sel_q <= shift_d[DCMD_READ_BIT];
`endif
                      if (shift_d[DCMD_READ_BIT]) begin
                        keys_q   <= i_Keys;
                        tx_cnt_q <= '0;
                        state_q  <= READ;
                      end else begin
                        fixed_q <= shift_d[DCMD_FIXED_BIT];
                      end
                    end
                    CMD_ADDR: begin
                      ptr_q   <= shift_d[3:0];
                      state_q <= DATA;
                    end
                    CMD_CTRL: begin
                      disp_on_q <= shift_d[3];
                      bright_q  <= shift_d[2:0];
                    end
                    default: ;
                  endcase
                end
              end
            end
          end
          READ: begin
            if (clk_fall) begin
              if (tx_cnt_q != TX_LAST) begin
                dio_oe_q  <= 1'b1;
                dio_out_q <= keys_q[0];
                keys_q    <= {1'b0, keys_q[READ_WIDTH-1:1]};
                tx_cnt_q  <= tx_cnt_q + CW'(1);
              end else begin
                dio_oe_q <= 1'b0;
                state_q  <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Read port sees pre-write contents on a same-cycle write.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) rdata_q <= 8'h00;
    else       rdata_q <= ram_q[i_Ram_RAddr];
  end

  assign io_SPI_Dio    = dio_oe_q ? dio_out_q : 1'bz;
  assign o_Read_Active = dio_oe_q;
  assign o_Ram_RData   = rdata_q;
  assign o_Disp_On     = disp_on_q;
  assign o_Disp_Bright = bright_q;
  assign o_Byte_Valid  = byte_vld_q;
  assign o_Byte        = byte_q;
endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
Synthesizable device-side model of the TM1638 3-wire serial interface (STB/CLK/DIO). It is the responder to the team's SPI command master: it decodes command, address and data bytes into a 16-byte display RAM and a display-control register. On a key-read command it drives the key-scan word back on DIO. It is used for on-FPGA loopback and for simulation benches of the master path.

Parameters:
READ_WIDTH, 32, key-scan word width returned on a read command; power of 2, must be ≥ 8.
SYNC_STAGES, 2, synchronizer depth for STB/CLK/DIO inputs; must be ≥ 2.

Ports:
i_Clk  in  1  system clock; SPI clock must be ≥ 8x slower.
i_Rst  in  1  reset.
i_SPI_Stb  in  1  strobe, active-low frame select.
i_SPI_Clk  in  1  serial clock, idle high.
io_SPI_Dio  inout  1  serial data; driven only during a read, otherwise high-Z.
i_Keys  in  READ_WIDTH  key-scan word, captured when a read command is decoded.
i_Ram_RAddr  in  4  display RAM read address.
o_Ram_RData  out  8  display RAM data; registered, 1-cycle latency.
o_Disp_On  out  1  display enable from the control command.
o_Disp_Bright  out  3  brightness from the control command.
o_Byte_Valid  out  1  1-cycle pulse per completed received byte.
o_Byte  out  8  last completed byte.
o_Read_Active  out  1  high while the responder owns DIO.

Behaviour:
- Reset: synchronous, active-high on i_Rst.
  - All outputs are 0; DIO is released; state is IDLE.
  - RAM is cleared to 0x00; address pointer is 0; mode is write/auto-increment.
  - Reset mid-frame aborts the frame immediately.
- Inputs pass through SYNC_STAGES flops (STB and CLK reset to 1). Edge detect runs on the synced CLK.
- Bits are LSB first. Receive samples DIO on the synced CLK rising edge. Transmit updates DIO on the synced CLK falling edge.
- States:
  - IDLE: waits for STB low → CMD.
  - CMD: shifts in 8 bits, then decodes the byte on bits [7:6]:
    - 01 data command. Bit1=1: read → READ. Bit1=0: write mode; bit2 selects fixed (1) or auto-increment (0); stay in CMD.
    - 11 address command: pointer = byte[3:0] → DATA.
    - 10 control command: o_Disp_On = bit3, o_Disp_Bright = bits[2:0]; stay in CMD.
    - 00 ignored.
  - DATA: each 8-bit byte writes RAM[pointer]. The pointer increments mod 16 (15 wraps to 0) unless in fixed mode. STB rising → IDLE.
  - READ:
    - i_Keys is latched in the cycle the read command decodes.
    - Bit 0 is driven at the next CLK falling edge; each later falling edge shifts one bit.
    - DIO is released after the falling edge following bit READ_WIDTH-1 is sampled, or on STB rising. Then → IDLE.
    - o_Read_Active equals the DIO output enable.
- STB rising in any state:
  - Discards a partial byte (bit count ≠ 0); no write, no pulse.
  - Returns to IDLE; the bit counter is cleared.
- The write/fixed mode persists across frames. The pointer persists only within a DATA frame.
- CLK edges while STB is high are ignored.
- o_Byte_Valid/o_Byte update in the cycle after the 8th rising edge, for every byte including commands. Bytes are not reported during READ.
- A RAM read on the same address as a same-cycle write returns the old data.

Optional Feature:
TM1638_RESP_ERR_EN:
- Defined: adds o_Frame_Err (1, sticky, cleared only by reset) and o_Err_Cnt (8, saturating at 255). Both count:
  - partial-byte STB aborts;
  - a read frame ended before READ_WIDTH bits;
  - data bytes in DATA arriving while read mode is selected.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package tm1638_pkg holds:
  - command-class constants: CMD_DATA=2'b01, CMD_CTRL=2'b10, CMD_ADDR=2'b11;
  - data-command bit positions: READ=1, FIXED=2;
  - the state enum: IDLE, CMD, DATA, READ;
  - RAM_DEPTH=16.
- One sub-module, tm1638_sync_edge: synchronizer plus rise/fall detect, instantiated for CLK, STB and DIO.

Test Plan:
- Frame 0x40; frame 0xC0, 0x11, 0x22, 0x33 → RAM[0..2] = 11, 22, 33; three data o_Byte_Valid pulses plus command pulses; RAM[3] = 00.
- Frame 0x44; frame 0xCF, 0xAA, 0xBB → RAM[15] = BB; RAM[0] unchanged. Repeat with 0x40 → RAM[15] = AA, RAM[0] = BB (wrap).
- Frame 0x8C → o_Disp_On = 1, o_Disp_Bright = 3'b100. Then frame 0x80 → o_Disp_On = 0.
- i_Keys = 0xDEADBEEF; frame 0x42 + 32 clocks → master samples 0xDEADBEEF LSB first; DIO is high-Z after the frame; o_Read_Active is high only during the 32 bits.
- STB rises after 5 bits of a data byte in DATA → no RAM write, no pulse, state IDLE. With the macro defined: o_Err_Cnt = 1, o_Frame_Err = 1.
- i_Rst asserted mid-read → DIO released the next cycle; RAM = 00, outputs 0. A new 0x40 frame then works normally.
